trace_buffer: RTL

Synthesizable multi-channel capture buffer for on-chip observation of CPU state (registers, flags, carry, PC) around a trigger event. Sits beside the CPU in the top wrapper: samples a packed bus of CHANNELS words on each qualified cycle into a circular memory, stops a programmable number of samples after the trigger, then streams the capture out, oldest sample first, one word at a time over a valid/ready port.

---
 rtl/trace_buffer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: circular multi-channel capture of CPU state around a trigger.
// Optional per-sample timestamp word enabled by defining TRACE_TIMESTAMP_EN.
module trace_buffer #(
    parameter int CHANNELS = 13,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2048,
    parameter int POST     = DEPTH / 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic                      i_valid,
    input  logic                      i_arm,
    input  logic                      i_trig,
    output logic                      o_armed,
    output logic                      o_triggered,
    output logic                      o_done,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [WIDTH-1:0]          o_rd_data,
    output logic                      o_rd_valid,
    input  logic                      i_rd_ready
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int NW   = CHANNELS + 1;
`else
    localparam int NW   = CHANNELS;
`endif
    localparam int DW   = NW * WIDTH;
    localparam int CW   = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] POST_C  = CNTW'(POST);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);
    localparam logic [CW-1:0]   LAST_CH = CW'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_POST,
        S_READ
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [CNTW-1:0]   post_q, post_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic [CNTW-1:0]   rd_left_q, rd_left_d;
    logic [CW-1:0]     rd_ch_q, rd_ch_d;
    logic              fetch_q, fetch_d;
    logic              load_q, load_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;

    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     ram_q;
    logic [DW-1:0]     wdata;
    logic              we;
    logic              re;
    logic [AW-1:0]     rd_addr;
    logic              go_read;
    logic              xfer;

`ifdef TRACE_TIMESTAMP_EN
    logic [WIDTH-1:0]  ts_q;

    // Free-running sample timestamp, restarted on every arm.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_q <= '0;
        end else if (i_arm) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wdata = {i_data, ts_q};
`else
    assign wdata = i_data;
`endif

    assign xfer = valid_q & i_rd_ready;

    // Next-state: capture control, trigger counting and readout sequencing.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        post_d    = post_q;
        rd_idx_d  = rd_idx_q;
        rd_left_d = rd_left_q;
        rd_ch_d   = rd_ch_q;
        fetch_d   = 1'b0;
        load_d    = 1'b0;
        valid_d   = valid_q;
        data_d    = data_q;
        we        = 1'b0;
        re        = 1'b0;
        rd_addr   = rd_idx_q;
        go_read   = 1'b0;

        if (i_arm) begin
            state_d  = S_PRE;
            wr_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            rd_ch_d  = '0;
            valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_PRE: begin
                    if (i_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q != DEPTH_C) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (i_trig) begin
                        state_d = S_POST;
                        post_d  = CNTW'(i_valid);
                        // Trigger sample alone may complete a POST=1 capture.
                        if (i_valid && (POST_C == ONE_C)) begin
                            go_read = 1'b1;
                        end
                    end
                end
                S_POST: begin
                    if (i_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        post_d   = post_q + 1'b1;
                        if (count_q != DEPTH_C) begin
                            count_d = count_q + 1'b1;
                        end
                        if (post_d == POST_C) begin
                            go_read = 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (fetch_q) begin
                        re      = 1'b1;
                        rd_addr = rd_idx_q;
                        load_d  = 1'b1;
                    end
                    if (load_q) begin
                        data_d  = ram_q[int'(rd_ch_q) * WIDTH +: WIDTH];
                        valid_d = 1'b1;
                    end
                    if (xfer) begin
                        valid_d = 1'b0;
                        if (rd_ch_q != LAST_CH) begin
                            rd_ch_d = rd_ch_q + 1'b1;
                            load_d  = 1'b1;
                        end else if (rd_left_q == ONE_C) begin
                            state_d = S_IDLE;
                        end else begin
                            // Next sample is read on the transfer edge
                            // so only one bubble cycle appears.
                            rd_ch_d   = '0;
                            rd_idx_d  = rd_idx_q + 1'b1;
                            rd_left_d = rd_left_q - 1'b1;
                            re        = 1'b1;
                            rd_addr   = rd_idx_q + 1'b1;
                            load_d    = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (go_read) begin
            state_d   = S_READ;
            rd_idx_d  = wr_ptr_d - count_d[AW-1:0];
            rd_left_d = count_d;
            rd_ch_d   = '0;
            fetch_d   = 1'b1;
            valid_d   = 1'b0;
        end
    end

    // Control and readout registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            post_q    <= '0;
            rd_idx_q  <= '0;
            rd_left_q <= '0;
            rd_ch_q   <= '0;
            fetch_q   <= 1'b0;
            load_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            rd_idx_q  <= rd_idx_d;
            rd_left_q <= rd_left_d;
            rd_ch_q   <= rd_ch_d;
            fetch_q   <= fetch_d;
            load_q    <= load_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    // Sample store: one write port, registered read, no reset.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[wr_ptr_q] <= wdata;
        end
        if (re) begin
            ram_q <= mem[rd_addr];
        end
    end

    assign o_armed     = (state_q == S_PRE);
    assign o_triggered = (state_q == S_POST);
    assign o_done      = (state_q == S_READ);
    assign o_count     = count_q;
    assign o_rd_data   = data_q;
    assign o_rd_valid  = valid_q;

endmodule
